// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: DEPTH-entry circular FIFO of {pc, inst} pairs.
// Latency: an entry pushed at edge N is on out_* from just after edge N; no same-cycle bypass.
// Backpressure: in_ready = !full (independent of out_ready); flush discards all handshakes and empties the queue.
module fetch_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [CW-1:0]  cnt;
    logic           push;
    logic           pop;
    entry_t         head_ent;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = cnt;

    // Handshakes in a flush cycle are dropped; fetch re-sends from the redirect target.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Head entry is gated to zero when empty so decode sees a harmless no-op.
    assign head_ent = mem[head];
    assign out_pc   = empty ? '0 : head_ent.pc;
    assign out_inst = empty ? '0 : head_ent.inst;

    // Storage needs no reset: stale contents are never visible because outputs are gated by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pc: in_pc, inst: in_inst};
        end
    end

    // Pointer and occupancy update; flush wins over any concurrent push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
